// File: rtl/dma_pcie_cfg_event_pkg.sv
// rtl/dma_pcie_cfg_event_pkg.sv - shared types and widths for the PCIe cfg event monitor
package dma_pcie_cfg_event_pkg;

  localparam int LTSSM_W = 6;
  localparam int LINK_W  = 2;
  localparam int EVT_W   = 3 + LTSSM_W + LINK_W;

  typedef struct packed {
    logic               hot_reset_rise;
    logic               link_chg;
    logic               ltssm_chg;
    logic [LTSSM_W-1:0] ltssm;
    logic [LINK_W-1:0]  link_status;
  } cfg_evt_t;

  typedef enum logic [1:0] {
    FLR_IDLE,
    FLR_REQ,
    FLR_WAIT,
    FLR_DONE
  } flr_state_t;

endpackage

// File: rtl/dma_pcie_cfg_evt_fifo.sv
// rtl/dma_pcie_cfg_evt_fifo.sv - first-word-fall-through sync FIFO with count-based full/empty
module dma_pcie_cfg_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         vld,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign vld     = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && vld;
  // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_pcie_cfg_event_mon.sv
// rtl/dma_pcie_cfg_event_mon.sv - cfg status monitor: event queue, error counters, FLR sequencer
module dma_pcie_cfg_event_mon
  import dma_pcie_cfg_event_pkg::*;
#(
  parameter int NUM_FUNC  = 4,
  parameter int EVT_DEPTH = 8,
  parameter int ERR_CNT_W = 16,
  localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  input  logic [LINK_W-1:0]    cfg_phy_link_status,
  input  logic [LTSSM_W-1:0]   cfg_ltssm_state,
  input  logic                 cfg_hot_reset_out,
  input  logic                 cfg_err_cor_out,
  input  logic                 cfg_err_nonfatal_out,
  input  logic                 cfg_err_fatal_out,
  input  logic [NUM_FUNC-1:0]  cfg_flr_in_process,
  output logic [NUM_FUNC-1:0]  cfg_flr_done,
  output logic                 flr_req_vld,
  input  logic                 flr_req_rdy,
  output logic [FW-1:0]        flr_req_func,
  input  logic                 flr_done_vld,
  output logic                 evt_vld,
  input  logic                 evt_rdy,
  output logic [EVT_W-1:0]     evt_data,
  output logic                 evt_ovf,
  input  logic                 evt_ovf_clr,
  output logic [ERR_CNT_W-1:0] err_cor_cnt,
  output logic [ERR_CNT_W-1:0] err_nf_cnt,
  output logic [ERR_CNT_W-1:0] err_fatal_cnt,
  input  logic                 err_cnt_clr
);

  logic [LINK_W-1:0]   s1_link, s2_link;
  logic [LTSSM_W-1:0]  s1_ltssm, s2_ltssm;
  logic                s1_hot, s2_hot, s1_cor, s1_nf, s1_fatal;
  logic [NUM_FUNC-1:0] s1_flr, s2_flr;
  logic                s1_vld, s2_vld;

  // s2_vld stays low for the priming cycle so the first snapshot never looks like a change.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      s1_link <= '0; s1_ltssm <= '0; s1_hot <= 1'b0; s1_flr <= '0;
      s1_cor <= 1'b0; s1_nf <= 1'b0; s1_fatal <= 1'b0; s1_vld <= 1'b0;
      s2_link <= '0; s2_ltssm <= '0; s2_hot <= 1'b0; s2_flr <= '0; s2_vld <= 1'b0;
    end else begin
      s1_link  <= cfg_phy_link_status;
      s1_ltssm <= cfg_ltssm_state;
      s1_hot   <= cfg_hot_reset_out;
      s1_flr   <= cfg_flr_in_process;
      s1_cor   <= cfg_err_cor_out;
      s1_nf    <= cfg_err_nonfatal_out;
      s1_fatal <= cfg_err_fatal_out;
      s1_vld   <= 1'b1;
      if (s1_vld) begin
        s2_link  <= s1_link;
        s2_ltssm <= s1_ltssm;
        s2_hot   <= s1_hot;
        s2_flr   <= s1_flr;
        s2_vld   <= 1'b1;
      end
    end
  end

  cfg_evt_t evt_new;
  logic     evt_push, evt_pop, fifo_full;

  always_comb begin
    evt_new.hot_reset_rise = s1_hot & ~s2_hot;
    evt_new.link_chg       = (s1_link != s2_link);
    evt_new.ltssm_chg      = (s1_ltssm != s2_ltssm);
    evt_new.ltssm          = s1_ltssm;
    evt_new.link_status    = s1_link;
  end

  assign evt_push = s2_vld & (evt_new.hot_reset_rise | evt_new.link_chg | evt_new.ltssm_chg);
  assign evt_pop  = evt_vld & evt_rdy;

  dma_pcie_cfg_evt_fifo #(.DEPTH(EVT_DEPTH), .W(EVT_W)) u_evt_fifo (
    .clk       (user_clk),
    .rst       (user_reset),
    .push      (evt_push),
    .push_data (evt_new),
    .pop       (evt_pop),
    .head      (evt_data),
    .vld       (evt_vld),
    .full      (fifo_full)
  );

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      evt_ovf       <= 1'b0;
      err_cor_cnt   <= '0;
      err_nf_cnt    <= '0;
      err_fatal_cnt <= '0;
    end else begin
      if (evt_push && fifo_full && !evt_pop) evt_ovf <= 1'b1;
      else if (evt_ovf_clr)                  evt_ovf <= 1'b0;
      if (err_cnt_clr) begin
        err_cor_cnt   <= '0;
        err_nf_cnt    <= '0;
        err_fatal_cnt <= '0;
      end else begin
        if (s1_cor   && err_cor_cnt   != '1) err_cor_cnt   <= err_cor_cnt + 1'b1;
        if (s1_nf    && err_nf_cnt    != '1) err_nf_cnt    <= err_nf_cnt + 1'b1;
        if (s1_fatal && err_fatal_cnt != '1) err_fatal_cnt <= err_fatal_cnt + 1'b1;
      end
    end
  end

  logic [NUM_FUNC-1:0] flr_rise, flr_fall, pending, hs_clr, func_onehot;
  flr_state_t          state;
  logic [FW-1:0]       rr_ptr, sel;
  logic                sel_found;
  logic [FW:0]         idx;

  assign flr_rise    = s2_vld ? (s1_flr & ~s2_flr) : '0;
  assign flr_fall    = s2_vld ? (~s1_flr & s2_flr) : '0;
  assign func_onehot = NUM_FUNC'(1) << flr_req_func;
  assign hs_clr      = (state == FLR_REQ && flr_req_rdy) ? func_onehot : '0;

  // Round-robin scan starting one past the last served function.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_FUNC; i++) begin
      idx = {1'b0, rr_ptr} + (FW+1)'(i);
      if (idx >= (FW+1)'(NUM_FUNC)) idx = idx - (FW+1)'(NUM_FUNC);
      if (!sel_found && pending[idx[FW-1:0]]) begin
        sel_found = 1'b1;
        sel       = idx[FW-1:0];
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) pending <= '0;
    else            pending <= (pending & ~hs_clr & ~flr_fall) | flr_rise;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state        <= FLR_IDLE;
      rr_ptr       <= '0;
      flr_req_vld  <= 1'b0;
      flr_req_func <= '0;
      cfg_flr_done <= '0;
    end else begin
      cfg_flr_done <= '0;
      case (state)
        FLR_IDLE: if (sel_found) begin
          flr_req_func <= sel;
          flr_req_vld  <= 1'b1;
          state        <= FLR_REQ;
        end
        FLR_REQ: if (flr_req_rdy) begin
          flr_req_vld <= 1'b0;
          rr_ptr      <= flr_req_func;
          state       <= FLR_WAIT;
        end
        FLR_WAIT: if (flr_done_vld) begin
          cfg_flr_done <= func_onehot;
          state        <= FLR_DONE;
        end
        FLR_DONE: state <= FLR_IDLE;
        default:  state <= FLR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_pcie_cfg_event_mon.sv
// tb/tb_dma_pcie_cfg_event_mon.sv - vector table and scoreboard bench for dma_pcie_cfg_event_mon
module tb_dma_pcie_cfg_event_mon;

  localparam int NUM_FUNC  = 4;
  localparam int EVT_DEPTH = 8;
  localparam int ERR_CNT_W = 16;
  localparam int FW        = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           cfg_phy_link_status = '0;
  logic [5:0]           cfg_ltssm_state = '0;
  logic                 cfg_hot_reset_out = 1'b0;
  logic                 cfg_err_cor_out = 1'b0;
  logic                 cfg_err_nonfatal_out = 1'b0;
  logic                 cfg_err_fatal_out = 1'b0;
  logic [NUM_FUNC-1:0]  cfg_flr_in_process = '0;
  logic [NUM_FUNC-1:0]  cfg_flr_done;
  logic                 flr_req_vld;
  logic                 flr_req_rdy = 1'b0;
  logic [FW-1:0]        flr_req_func;
  logic                 flr_done_vld = 1'b0;
  logic                 evt_vld;
  logic                 evt_rdy = 1'b1;
  logic [10:0]          evt_data;
  logic                 evt_ovf;
  logic                 evt_ovf_clr = 1'b0;
  logic [ERR_CNT_W-1:0] err_cor_cnt, err_nf_cnt, err_fatal_cnt;
  logic                 err_cnt_clr = 1'b0;

  always #5 clk = ~clk;

  dma_pcie_cfg_event_mon #(.NUM_FUNC(NUM_FUNC), .EVT_DEPTH(EVT_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .user_clk             (clk),
    .user_reset           (rst),
    .cfg_phy_link_status  (cfg_phy_link_status),
    .cfg_ltssm_state      (cfg_ltssm_state),
    .cfg_hot_reset_out    (cfg_hot_reset_out),
    .cfg_err_cor_out      (cfg_err_cor_out),
    .cfg_err_nonfatal_out (cfg_err_nonfatal_out),
    .cfg_err_fatal_out    (cfg_err_fatal_out),
    .cfg_flr_in_process   (cfg_flr_in_process),
    .cfg_flr_done         (cfg_flr_done),
    .flr_req_vld          (flr_req_vld),
    .flr_req_rdy          (flr_req_rdy),
    .flr_req_func         (flr_req_func),
    .flr_done_vld         (flr_done_vld),
    .evt_vld              (evt_vld),
    .evt_rdy              (evt_rdy),
    .evt_data             (evt_data),
    .evt_ovf              (evt_ovf),
    .evt_ovf_clr          (evt_ovf_clr),
    .err_cor_cnt          (err_cor_cnt),
    .err_nf_cnt           (err_nf_cnt),
    .err_fatal_cnt        (err_fatal_cnt),
    .err_cnt_clr          (err_cnt_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [10:0] evt_q[$];
  int flr_q[$];

  typedef struct {
    logic [5:0] ltssm;
    logic [1:0] link;
    logic       hot;
    logic       exp_vld;
    logic [2:0] exp_flags;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Event scoreboard: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && evt_vld && evt_rdy) begin
      if (evt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got 0x%0h with no entry expected", evt_data);
      end else begin
        check("evt_data", 32'(evt_data), 32'(evt_q.pop_front()));
      end
    end
  end

  task automatic req_handshake(input int budget, output int f);
    int n;
    n = 0;
    f = -1;
    @(negedge clk);
    while (!flr_req_vld && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!flr_req_vld) begin
      checks++;
      errors++;
      $display("FAIL flr_req_timeout: got no request within %0d cycles, expected one", budget);
      return;
    end
    f = (flr_q.size() != 0) ? flr_q.pop_front() : -1;
    check("flr_req_func", 32'(flr_req_func), 32'(f));
    flr_req_rdy = 1'b1;
    @(posedge clk);
    #1 flr_req_rdy = 1'b0;
    @(negedge clk);
    check("flr_req_drop", 32'(flr_req_vld), 32'd0);
  endtask

  task automatic give_done(input int f);
    logic [NUM_FUNC-1:0] exp;
    exp = (f >= 0) ? (NUM_FUNC'(1) << f) : '0;
    tick();
    flr_done_vld = 1'b1;
    tick();
    flr_done_vld = 1'b0;
    @(negedge clk);
    check("flr_done_pulse", 32'(cfg_flr_done), 32'(exp));
    @(negedge clk);
    check("flr_done_clear", 32'(cfg_flr_done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    logic seen_a, seen_b;

    vecs[0] = '{ltssm: 6'h11, link: 2'd2, hot: 1'b0, exp_vld: 1'b1, exp_flags: 3'b010};
    vecs[1] = '{ltssm: 6'h11, link: 2'd2, hot: 1'b1, exp_vld: 1'b1, exp_flags: 3'b100};
    vecs[2] = '{ltssm: 6'h11, link: 2'd2, hot: 1'b0, exp_vld: 1'b0, exp_flags: 3'b000};
    vecs[3] = '{ltssm: 6'h2A, link: 2'd3, hot: 1'b1, exp_vld: 1'b1, exp_flags: 3'b111};
    vecs[4] = '{ltssm: 6'h2A, link: 2'd3, hot: 1'b1, exp_vld: 1'b0, exp_flags: 3'b000};
    vecs[5] = '{ltssm: 6'h2A, link: 2'd1, hot: 1'b0, exp_vld: 1'b1, exp_flags: 3'b010};
    vecs[6] = '{ltssm: 6'h3F, link: 2'd1, hot: 1'b0, exp_vld: 1'b1, exp_flags: 3'b001};
    vecs[7] = '{ltssm: 6'h3F, link: 2'd1, hot: 1'b1, exp_vld: 1'b1, exp_flags: 3'b100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_evt_vld", 32'(evt_vld), 32'd0);
    check("rst_evt_data", 32'(evt_data), 32'd0);
    check("rst_evt_ovf", 32'(evt_ovf), 32'd0);
    check("rst_err_cnts", 32'(err_cor_cnt | err_nf_cnt | err_fatal_cnt), 32'd0);
    check("rst_flr_req", {29'd0, flr_req_vld, flr_req_func}, 32'd0);
    check("rst_flr_done", 32'(cfg_flr_done), 32'd0);
    rst = 1'b0;
    tick(4);

    // First event latency: change at edge E, evt_vld visible after E+2.
    cfg_ltssm_state = 6'h11;
    evt_q.push_back({3'b001, 6'h11, 2'b00});
    @(negedge clk);
    @(negedge clk);
    check("evt_lat_n1", 32'(evt_vld), 32'd0);
    @(negedge clk);
    check("evt_lat_n2", 32'(evt_vld), 32'd1);
    tick(2);
    @(negedge clk);
    check("evt_first_drained", 32'(evt_vld), 32'd0);

    for (int i = 0; i < 8; i++) begin
      cfg_ltssm_state     = vecs[i].ltssm;
      cfg_phy_link_status = vecs[i].link;
      cfg_hot_reset_out   = vecs[i].hot;
      if (vecs[i].exp_vld) evt_q.push_back({vecs[i].exp_flags, vecs[i].ltssm, vecs[i].link});
      tick();
    end
    tick(6);
    check("vec_drain", 32'(evt_q.size()), 32'd0);

    // Overflow: nine changes into an eight-deep queue with the sink stalled.
    evt_rdy = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      cfg_ltssm_state = 6'(v);
      if (v <= 8) evt_q.push_back({3'b001, 6'(v), 2'b01});
      tick();
    end
    tick(4);
    @(negedge clk);
    check("ovf_set", 32'(evt_ovf), 32'd1);
    check("ovf_full_vld", 32'(evt_vld), 32'd1);
    evt_ovf_clr = 1'b1;
    tick();
    evt_ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(evt_ovf), 32'd0);
    evt_rdy = 1'b1;
    tick(12);
    check("ovf_drain", 32'(evt_q.size()), 32'd0);
    check("ovf_drain_vld", 32'(evt_vld), 32'd0);

    tick();
    cfg_err_nonfatal_out = 1'b1;
    tick();
    cfg_err_nonfatal_out = 1'b0;
    @(negedge clk);
    check("nf_lat1", 32'(err_nf_cnt), 32'd0);
    @(negedge clk);
    check("nf_lat2", 32'(err_nf_cnt), 32'd1);
    tick();
    cfg_err_fatal_out = 1'b1;
    tick(2);
    cfg_err_fatal_out = 1'b0;
    tick(3);
    check("fatal_two", 32'(err_fatal_cnt), 32'd2);
    cfg_err_cor_out = 1'b1;
    tick(66000);
    check("cor_saturate", 32'(err_cor_cnt), 32'h0000FFFF);
    err_cnt_clr     = 1'b1;
    cfg_err_cor_out = 1'b0;
    tick();
    err_cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins", 32'(err_cor_cnt), 32'd0);
    check("cnt_clr_all", 32'(err_nf_cnt | err_fatal_cnt), 32'd0);
    tick(3);
    check("cnt_clr_stays", 32'(err_cor_cnt), 32'd0);

    // FLR on func 1: request latency, leaves rr pointer at 1.
    flr_q.push_back(1);
    cfg_flr_in_process = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("flr_lat_n2", 32'(flr_req_vld), 32'd0);
    @(negedge clk);
    check("flr_lat_n3", 32'(flr_req_vld), 32'd1);
    req_handshake(10, f);
    give_done(f);
    cfg_flr_in_process = 4'b0000;
    tick(3);

    // Simultaneous rise on 2 and 0 with rr at 1: served 2 then 0.
    flr_q.push_back(2);
    flr_q.push_back(0);
    cfg_flr_in_process = 4'b0101;
    tick(6);
    @(negedge clk);
    check("flr_hold_vld", 32'(flr_req_vld), 32'd1);
    req_handshake(10, f);
    give_done(f);
    req_handshake(20, f);
    give_done(f);
    cfg_flr_in_process = 4'b0000;
    tick(3);

    // Func 3 rises and falls while func 1 is in WAIT: must be cancelled.
    flr_q.push_back(1);
    cfg_flr_in_process = 4'b0010;
    req_handshake(20, f);
    tick();
    cfg_flr_in_process = 4'b1010;
    tick(2);
    cfg_flr_in_process = 4'b0010;
    tick(4);
    give_done(f);
    seen_a = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (flr_req_vld || cfg_flr_done[3]) seen_a = 1'b1;
    end
    check("flr_cancel", 32'(seen_a), 32'd0);

    // Reset while in WAIT with a queued event and nonzero counters.
    flr_q.push_back(2);
    cfg_flr_in_process = 4'b0100;
    req_handshake(20, f);
    evt_rdy             = 1'b0;
    cfg_ltssm_state     = 6'h15;
    cfg_phy_link_status = 2'b10;
    cfg_err_fatal_out   = 1'b1;
    tick(4);
    cfg_err_fatal_out = 1'b0;
    @(negedge clk);
    check("pre_rst_evt", 32'(evt_vld), 32'd1);
    check("pre_rst_fatal", 32'(err_fatal_cnt != '0), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_evt", {20'd0, evt_vld, evt_data}, 32'd0);
    check("arst_ovf", 32'(evt_ovf), 32'd0);
    check("arst_flr", {25'd0, flr_req_vld, flr_req_func, cfg_flr_done}, 32'd0);
    check("arst_cnts", 32'(err_cor_cnt | err_nf_cnt | err_fatal_cnt), 32'd0);
    evt_q.delete();
    flr_q.delete();
    tick(2);
    rst     = 1'b0;
    evt_rdy = 1'b1;
    seen_a  = 1'b0;
    seen_b  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (evt_vld) seen_a = 1'b1;
      if (flr_req_vld) seen_b = 1'b1;
    end
    check("post_rst_no_evt", 32'(seen_a), 32'd0);
    check("post_rst_no_flr", 32'(seen_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
